// File: rtl/lectura_rtc.sv
// lectura_rtc: reads the 9 BCD time/date/timer registers of the RTC over its multiplexed AD bus.
// Latency: start to done = 10*(2*T_PH + 2*T_GAP) + 2 cycles (122 at T_PH=4, T_GAP=2).
// Backpressure: none. start is accepted in IDLE only; start pulses while busy are dropped.
//
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   start               - single-cycle refresh request (ignored while busy)
//   SF_24_12            - 1 = 12h mode: hour outputs masked to 5 bits, AM_PM valid
//   AD_in               - data sampled from the RTC bus
//   AD_out, AD_oe       - address/data driven onto the RTC bus and its output enable
//   CS_n, AD_n, WR_n, RD_n - RTC chip select and strobes, all active low
//   busy, done          - sequence in progress / one-cycle commit pulse
//   seg..hora_t, AM_PM  - committed BCD values, updated together on the done cycle

module lectura_rtc #(
    parameter int unsigned T_PH  = 4,   // cycles each address/data strobe is held
    parameter int unsigned T_GAP = 2    // idle cycles between phases
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       SF_24_12,
    input  logic [7:0] AD_in,
    output logic [7:0] AD_out,
    output logic       AD_oe,
    output logic       CS_n,
    output logic       AD_n,
    output logic       WR_n,
    output logic       RD_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] day,
    output logic [7:0] month,
    output logic [7:0] year,
    output logic [7:0] seg_t,
    output logic [7:0] min_t,
    output logic [7:0] hora_t,
    output logic       AM_PM
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP1,
        S_DATA,
        S_GAP2,
        S_COMMIT
    } state_t;

    localparam logic [3:0] PH_LAST  = 4'(T_PH - 1);
    localparam logic [3:0] GAP_LAST = 4'(T_GAP - 1);
    localparam logic [3:0] IDX_LAST = 4'd9;
    localparam logic [7:0] CMD      = 8'hF0;   // transfer command, also its own address

    // Transaction index 0 is the command write; 1..9 are the register reads.
    function automatic logic [7:0] addr_of(input logic [3:0] idx);
        logic [7:0] a;
        case (idx)
            4'd0:                                  a = CMD;
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6:    a = 8'h20 + {4'd0, idx};  // 0x21..0x26
            4'd7, 4'd8, 4'd9:                      a = 8'h3A + {4'd0, idx};  // 0x41..0x43
            default:                               a = 8'h00;
        endcase
        return a;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d;
    logic       capture;   // last DATA cycle of a read: latch AD_in
    logic       commit;    // COMMIT cycle: publish the shadow registers

    // Shadow copy of the registers being read; outputs only see it at COMMIT.
    logic [7:0] shadow_q [1:9];

    // Bus pins are registered from the next state so they are glitch-free and
    // line up exactly with state_q.
    logic [7:0] ad_out_q, ad_out_d;
    logic       ad_oe_q, ad_oe_d;
    logic       cs_n_q, cs_n_d;
    logic       ad_n_q, ad_n_d;
    logic       wr_n_q, wr_n_d;
    logic       rd_n_q, rd_n_d;
    logic       busy_q, done_q;

    logic [7:0] seg_q, min_q, hora_q, day_q, month_q, year_q;
    logic [7:0] seg_t_q, min_t_q, hora_t_q;
    logic       am_pm_q;
    logic [7:0] hour_mask;

    // ------------------------------------------------------------------
    // Sequencer: next state, phase counter, transaction index
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 4'd1;
        idx_d   = idx_q;
        capture = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_ADDR;
                    idx_d   = '0;
                end
            end
            S_ADDR: begin
                if (cnt_q == PH_LAST) begin
                    state_d = S_GAP1;
                    cnt_d   = '0;
                end
            end
            S_GAP1: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (cnt_q == PH_LAST) begin
                    state_d = S_GAP2;
                    cnt_d   = '0;
                    // Sample only at the end of the strobe, when RTC data is settled.
                    capture = (idx_q != 4'd0);
                end
            end
            S_GAP2: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_COMMIT;
                    end else begin
                        state_d = S_ADDR;
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end
            S_COMMIT: begin
                cnt_d   = '0;
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus pin decode for the cycle about to start
    // ------------------------------------------------------------------
    always_comb begin
        cs_n_d   = 1'b1;
        ad_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = 8'h00;
        case (state_d)
            S_ADDR: begin
                cs_n_d   = 1'b0;
                ad_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_of(idx_d);
            end
            S_GAP1: begin
                // The command write keeps driving so its data is stable before WR_n falls.
                if (idx_d == 4'd0) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = CMD;
                end
            end
            S_DATA: begin
                cs_n_d = 1'b0;
                if (idx_d == 4'd0) begin
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = CMD;
                end else begin
                    rd_n_d = 1'b0;   // bus released: the RTC drives during reads
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            ad_out_q <= 8'h00;
            ad_oe_q  <= 1'b0;
            cs_n_q   <= 1'b1;
            ad_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
            cs_n_q   <= cs_n_d;
            ad_n_q   <= ad_n_d;
            wr_n_q   <= wr_n_d;
            rd_n_q   <= rd_n_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= commit;
        end
    end

    // ------------------------------------------------------------------
    // Shadow capture and atomic commit
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i <= 9; i++) begin
                shadow_q[i] <= 8'h00;
            end
        end else if (capture) begin
            shadow_q[idx_q] <= AD_in;
        end
    end

    // 12h mode keeps bits 4:0 (bit 5 is the PM flag); 24h mode keeps bits 5:0.
    assign hour_mask = SF_24_12 ? 8'h1F : 8'h3F;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q    <= 8'h00;
            min_q    <= 8'h00;
            hora_q   <= 8'h00;
            day_q    <= 8'h00;
            month_q  <= 8'h00;
            year_q   <= 8'h00;
            seg_t_q  <= 8'h00;
            min_t_q  <= 8'h00;
            hora_t_q <= 8'h00;
            am_pm_q  <= 1'b0;
        end else if (commit) begin
            seg_q    <= shadow_q[1];
            min_q    <= shadow_q[2];
            hora_q   <= shadow_q[3] & hour_mask;
            day_q    <= shadow_q[4];
            month_q  <= shadow_q[5];
            year_q   <= shadow_q[6];
            seg_t_q  <= shadow_q[7];
            min_t_q  <= shadow_q[8];
            hora_t_q <= shadow_q[9] & hour_mask;
            am_pm_q  <= shadow_q[3][5] & SF_24_12;
        end
    end

    assign AD_out = ad_out_q;
    assign AD_oe  = ad_oe_q;
    assign CS_n   = cs_n_q;
    assign AD_n   = ad_n_q;
    assign WR_n   = wr_n_q;
    assign RD_n   = rd_n_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign seg    = seg_q;
    assign min    = min_q;
    assign hora   = hora_q;
    assign day    = day_q;
    assign month  = month_q;
    assign year   = year_q;
    assign seg_t  = seg_t_q;
    assign min_t  = min_t_q;
    assign hora_t = hora_t_q;
    assign AM_PM  = am_pm_q;

endmodule

// File: tb/tb_lectura_rtc.sv
module tb_lectura_rtc;

    localparam int LAT_A = 10 * (2 * 4 + 2 * 2) + 2;   // 122
    localparam int LAT_B = 10 * (2 * 2 + 2 * 1) + 2;   // 62
    localparam logic [1:0] K_I = 2'd0, K_A = 2'd1, K_W = 2'd2, K_R = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;
    logic sf = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;
    logic [7:0] ad_in_a = 8'h00, ad_in_b = 8'h00;

    wire [7:0] ad_out_a, ad_out_b;
    wire ad_oe_a, cs_n_a, ad_n_a, wr_n_a, rd_n_a, busy_a, done_a, ampm_a;
    wire ad_oe_b, cs_n_b, ad_n_b, wr_n_b, rd_n_b, busy_b, done_b, ampm_b;
    wire [0:8][7:0] out_a, out_b;   // seg,min,hora,day,month,year,seg_t,min_t,hora_t

    lectura_rtc u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .SF_24_12(sf), .AD_in(ad_in_a),
        .AD_out(ad_out_a), .AD_oe(ad_oe_a), .CS_n(cs_n_a), .AD_n(ad_n_a), .WR_n(wr_n_a),
        .RD_n(rd_n_a), .busy(busy_a), .done(done_a),
        .seg(out_a[0]), .min(out_a[1]), .hora(out_a[2]), .day(out_a[3]), .month(out_a[4]),
        .year(out_a[5]), .seg_t(out_a[6]), .min_t(out_a[7]), .hora_t(out_a[8]), .AM_PM(ampm_a)
    );

    lectura_rtc #(.T_PH(2), .T_GAP(1)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .SF_24_12(sf), .AD_in(ad_in_b),
        .AD_out(ad_out_b), .AD_oe(ad_oe_b), .CS_n(cs_n_b), .AD_n(ad_n_b), .WR_n(wr_n_b),
        .RD_n(rd_n_b), .busy(busy_b), .done(done_b),
        .seg(out_b[0]), .min(out_b[1]), .hora(out_b[2]), .day(out_b[3]), .month(out_b[4]),
        .year(out_b[5]), .seg_t(out_b[6]), .min_t(out_b[7]), .hora_t(out_b[8]), .AM_PM(ampm_b)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- RTC behavioural model ----------------
    logic [7:0] rtc_mem [0:8];
    logic [7:0] reg_addr [0:8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    logic [7:0] bus_addr [0:9] = '{8'hF0, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    function automatic int reg_idx(input logic [7:0] a);
        for (int i = 0; i < 9; i++) if (reg_addr[i] == a) return i;
        return -1;
    endfunction

    // Valid data only on the last cycle of the read strobe; garbage otherwise.
    function automatic logic [7:0] rtc_drive(input logic [7:0] a, input int run, input int tph);
        int k;
        logic [7:0] v;
        k = reg_idx(a);
        v = (k >= 0) ? rtc_mem[k] : 8'h00;
        if (run == tph) return v;
        return v ^ 8'($urandom_range(1, 255));
    endfunction

    logic [7:0] lat_a = 8'h00, lat_b = 8'h00;
    int rd_run_a = 0, rd_run_b = 0;

    always @(negedge clk) begin
        if (!ad_n_a) lat_a = ad_out_a;
        if (!rd_n_a) rd_run_a++; else rd_run_a = 0;
        ad_in_a = rtc_drive(lat_a, rd_run_a, 4);
        if (!ad_n_b) lat_b = ad_out_b;
        if (!rd_n_b) rd_run_b++; else rd_run_b = 0;
        ad_in_b = rtc_drive(lat_b, rd_run_b, 2);
    end

    // ---------------- bus monitor (DUT A) ----------------
    logic [17:0] ph_log [$];   // {kind, addr/data, length}
    logic [1:0] cur_kind = K_I;
    logic [7:0] cur_val = 8'h00;
    int cur_len = 0, idle_run = 0, min_gap = 1000, n_started = 0, viol = 0;

    always @(negedge clk) begin
        logic [1:0] k;
        k = !ad_n_a ? K_A : (!rd_n_a ? K_R : (!wr_n_a ? K_W : K_I));
        if (!rd_n_a && ad_oe_a) viol++;
        if (!rd_n_a && !wr_n_a) viol++;
        if (k != K_I && cs_n_a) viol++;
        if ((k == K_A || k == K_W) && !ad_oe_a) viol++;
        if (k != cur_kind) begin
            if (cur_kind != K_I) ph_log.push_back({cur_kind, cur_val, 8'(cur_len)});
            if (k != K_I) begin
                if (n_started > 0 && idle_run < min_gap) min_gap = idle_run;
                n_started++;
                cur_val = (k == K_R) ? 8'h00 : ad_out_a;
            end
            cur_len = 0;
        end
        cur_kind = k;
        if (k == K_I) idle_run++;
        else begin
            idle_run = 0;
            cur_len++;
        end
    end

    task automatic mon_clear();
        ph_log.delete();
        viol = 0;
        min_gap = 1000;
        n_started = 0;
    endtask

    task automatic check_bus(input string tag);
        logic [17:0] e;
        check({tag, "_nphase"}, 32'(ph_log.size()), 32'd20);
        for (int p = 0; p < 10; p++) begin
            e = {K_A, bus_addr[p], 8'd4};
            check($sformatf("%s_ph%0d_addr", tag, p),
                  (2 * p < ph_log.size()) ? 32'(ph_log[2 * p]) : 32'hDEAD, 32'(e));
            e = (p == 0) ? {K_W, 8'hF0, 8'd4} : {K_R, 8'h00, 8'd4};
            check($sformatf("%s_ph%0d_data", tag, p),
                  (2 * p + 1 < ph_log.size()) ? 32'(ph_log[2 * p + 1]) : 32'hDEAD, 32'(e));
        end
        check({tag, "_bus_rules"}, 32'(viol), 32'd0);
        check({tag, "_gap_ge2"}, 32'(min_gap >= 2), 32'd1);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [0:8][7:0] model(input logic [0:8][7:0] r, input logic s,
                                               output logic amp);
        logic [0:8][7:0] o;
        int h, ht;
        o  = r;
        h  = int'(r[2]);
        ht = int'(r[8]);
        o[2] = 8'(s ? h % 32 : h % 64);
        o[8] = 8'(s ? ht % 32 : ht % 64);
        amp  = s && ((h / 32) % 2 == 1);
        return o;
    endfunction

    // ---------------- sequence driver ----------------
    // mode 0: plain; 1: extra starts at cycles 5 and 60; 2: start during COMMIT.
    task automatic run_seq(input bit on_b, input logic [0:8][7:0] regs, input logic sf_v,
                           input int mode, output int lat, output int ndone, output int torn,
                           output int busy_err, output logic [0:8][7:0] res, output logic res_amp);
        logic [0:8][7:0] old, cur;
        logic old_amp, cur_amp, d, b;
        int lat_exp;
        bit seen;
        lat_exp = on_b ? LAT_B : LAT_A;
        for (int i = 0; i < 9; i++) rtc_mem[i] = regs[i];
        @(negedge clk);
        old = on_b ? out_b : out_a;
        old_amp = on_b ? ampm_b : ampm_a;
        sf = ~sf_v;   // flipped back before COMMIT: only the COMMIT value may matter
        if (on_b) start_b = 1'b1; else start_a = 1'b1;
        lat = -1; ndone = 0; torn = 0; busy_err = 0; res = '0; res_amp = 1'b0; seen = 0;
        for (int c = 1; c <= lat_exp + 40; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            if (c == lat_exp - 20) sf = sf_v;
            if (mode == 1 && (c == 5 || c == 60)) start_a = 1'b1;
            if (mode == 2 && c == lat_exp - 1) begin
                if (on_b) start_b = 1'b1; else start_a = 1'b1;
            end
            cur = on_b ? out_b : out_a;
            cur_amp = on_b ? ampm_b : ampm_a;
            d = on_b ? done_b : done_a;
            b = on_b ? busy_b : busy_a;
            if (d) begin
                ndone++;
                if (!seen) begin
                    seen = 1;
                    lat = c;
                    res = cur;
                    res_amp = cur_amp;
                end
            end else if (!seen && (cur !== old || cur_amp !== old_amp)) begin
                torn++;
            end
            if (c < lat_exp && !b) busy_err++;
            if (c >= lat_exp && b) busy_err++;
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input bit on_b, input logic [0:8][7:0] regs,
                                 input logic sf_v, input int mode,
                                 input logic [0:8][7:0] exp_o, input logic exp_amp);
        int lat, ndone, torn, berr;
        logic [0:8][7:0] res;
        logic res_amp;
        if (!on_b) mon_clear();
        run_seq(on_b, regs, sf_v, mode, lat, ndone, torn, berr, res, res_amp);
        check({tag, "_latency"}, 32'(lat), 32'(on_b ? LAT_B : LAT_A));
        check({tag, "_ndone"}, 32'(ndone), 32'd1);
        check({tag, "_torn"}, 32'(torn), 32'd0);
        check({tag, "_busy"}, 32'(berr), 32'd0);
        for (int i = 0; i < 9; i++)
            check($sformatf("%s_out%0d", tag, i), 32'(res[i]), 32'(exp_o[i]));
        check({tag, "_ampm"}, 32'(res_amp), 32'(exp_amp));
        if (!on_b) check_bus(tag);
    endtask

    typedef struct packed {
        logic [0:8][7:0] regs;
        logic            sf;
        logic [0:8][7:0] exp_o;
        logic            exp_amp;
    } vec_t;

    initial begin
        vec_t vecs [0:4];
        logic [0:8][7:0] r, e;
        logic s, amp;

        vecs[0] = '{regs: {8'h45, 8'h30, 8'h13, 8'h25, 8'h12, 8'h16, 8'h10, 8'h05, 8'h01}, sf: 1'b0,
                    exp_o: {8'h45, 8'h30, 8'h13, 8'h25, 8'h12, 8'h16, 8'h10, 8'h05, 8'h01}, exp_amp: 1'b0};
        vecs[1] = '{regs: {8'h00, 8'h59, 8'h31, 8'h31, 8'h12, 8'h99, 8'h59, 8'h59, 8'h23}, sf: 1'b1,
                    exp_o: {8'h00, 8'h59, 8'h11, 8'h31, 8'h12, 8'h99, 8'h59, 8'h59, 8'h03}, exp_amp: 1'b1};
        vecs[2] = '{regs: {8'h07, 8'h08, 8'h11, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11}, sf: 1'b1,
                    exp_o: {8'h07, 8'h08, 8'h11, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11}, exp_amp: 1'b0};
        vecs[3] = '{regs: {8'hFF, 8'hA5, 8'h72, 8'h5A, 8'hC3, 8'h3C, 8'h81, 8'h7E, 8'hE5}, sf: 1'b0,
                    exp_o: {8'hFF, 8'hA5, 8'h32, 8'h5A, 8'hC3, 8'h3C, 8'h81, 8'h7E, 8'h25}, exp_amp: 1'b0};
        vecs[4] = '{regs: {8'hFF, 8'hA5, 8'h72, 8'h5A, 8'hC3, 8'h3C, 8'h81, 8'h7E, 8'hE5}, sf: 1'b1,
                    exp_o: {8'hFF, 8'hA5, 8'h12, 8'h5A, 8'hC3, 8'h3C, 8'h81, 8'h7E, 8'h05}, exp_amp: 1'b1};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", 32'(cs_n_a), 32'd1);
        check("rst_ad_n", 32'(ad_n_a), 32'd1);
        check("rst_wr_n", 32'(wr_n_a), 32'd1);
        check("rst_rd_n", 32'(rd_n_a), 32'd1);
        check("rst_ad_oe", 32'(ad_oe_a), 32'd0);
        check("rst_ad_out", 32'(ad_out_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_outs", 32'(out_a == '0), 32'd1);
        check("rst_ampm", 32'(ampm_a), 32'd0);
        check("rst_b_cs_n", 32'(cs_n_b), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven vectors
        for (int v = 0; v < 5; v++)
            run_and_check($sformatf("vec%0d", v), 1'b0, vecs[v].regs, vecs[v].sf, 0,
                          vecs[v].exp_o, vecs[v].exp_amp);

        // Extra starts while busy; every output byte changes at commit
        r = {8'h11, 8'h22, 8'h03, 8'h44, 8'h05, 8'h16, 8'h27, 8'h38, 8'h09};
        e = model(r, 1'b0, amp);
        run_and_check("extra_start", 1'b0, r, 1'b0, 1, e, amp);

        // Start in the COMMIT cycle is ignored
        r = {8'h12, 8'h34, 8'h23, 8'h28, 8'h02, 8'h24, 8'h33, 8'h44, 8'h22};
        e = model(r, 1'b1, amp);
        run_and_check("commit_start", 1'b0, r, 1'b1, 2, e, amp);

        // Reset in the DATA phase of index 4
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (55) @(negedge clk);
        check("mid_rd_active", 32'(rd_n_a), 32'd0);
        check("mid_rd_addr", 32'(lat_a), 32'h24);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_cs_n", 32'(cs_n_a), 32'd1);
        check("mid_rst_rd_n", 32'(rd_n_a), 32'd1);
        check("mid_rst_strobes", 32'({ad_n_a, wr_n_a}), 32'd3);
        check("mid_rst_ad_oe", 32'(ad_oe_a), 32'd0);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_outs", 32'(out_a == '0), 32'd1);
        check("mid_rst_ampm", 32'(ampm_a), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        r = {8'h01, 8'h02, 8'h33, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h29};
        e = model(r, 1'b1, amp);
        run_and_check("after_rst", 1'b0, r, 1'b1, 0, e, amp);

        // Randomised runs against the reference model
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 9; i++) r[i] = 8'($urandom);
            s = 1'($urandom_range(0, 1));
            e = model(r, s, amp);
            run_and_check($sformatf("rnd%0d", n), 1'b0, r, s, 0, e, amp);
        end

        // Short-timing instance
        run_and_check("b_vec0", 1'b1, vecs[0].regs, vecs[0].sf, 0, vecs[0].exp_o, vecs[0].exp_amp);
        run_and_check("b_vec4", 1'b1, vecs[4].regs, vecs[4].sf, 0, vecs[4].exp_o, vecs[4].exp_amp);
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 9; i++) r[i] = 8'($urandom);
            s = 1'($urandom_range(0, 1));
            e = model(r, s, amp);
            run_and_check($sformatf("b_rnd%0d", n), 1'b1, r, s, 0, e, amp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lectura_rtc.md
Name: lectura_rtc

Overview:
- Read-side sequencer for the external RTC's multiplexed address/data bus; counterpart of the write path that drives time/date/timer values into the RTC.
- On a start pulse:
  - issues the RTC's 0xF0 transfer command;
  - reads 9 BCD registers (seconds, minutes, hours, day, month, year, timer seconds/minutes/hours) with address-strobe/read-strobe bus cycles;
  - commits all 9 registers atomically to its outputs.
- Outputs feed the display and programming logic.

Parameters:
- T_PH, 4, clock cycles each strobe (address or data phase) is held active.
- T_GAP, 2, idle cycles (all strobes high) between phases.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to refresh all registers
- SF_24_12  in  1  1 = 12h format: hour outputs masked, AM_PM valid
- AD_in  in  8  data sampled from the RTC bus
- AD_out  out  8  address/data driven onto the RTC bus
- AD_oe  out  1  1 = AD_out drives the bus
- CS_n  out  1  chip select, active low
- AD_n  out  1  address strobe, active low
- WR_n  out  1  write strobe, active low
- RD_n  out  1  read strobe, active low
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on commit
- seg, min, hora, day, month, year, seg_t, min_t, hora_t  out  8 each  committed BCD values
- AM_PM  out  1  hours bit 5 when SF_24_12=1, else 0

Behaviour:
Reset (reset=0, asynchronous):
- State IDLE.
- CS_n, AD_n, WR_n, RD_n = 1; AD_oe = 0; AD_out = 0x00; busy = 0; done = 0.
- All data outputs and AM_PM = 0; shadow registers = 0; index = 0.

Transaction list, fixed order, index 0..9:
- 0: write command 0xF0 to address 0xF0.
- 1..6: read 0x21, 0x22, 0x23, 0x24, 0x25, 0x26 (seg, min, hora, day, month, year).
- 7..9: read 0x41, 0x42, 0x43 (seg_t, min_t, hora_t).

States: IDLE, ADDR, GAP1, DATA, GAP2, COMMIT.
- IDLE:
  - start=1 -> ADDR, index = 0, busy = 1.
  - start ignored while busy.
- ADDR, T_PH cycles:
  - CS_n = 0, AD_n = 0, WR_n = 0, AD_oe = 1, AD_out = address[index].
  - Exits -> GAP1.
- GAP1, T_GAP cycles:
  - All strobes high.
  - AD_oe = 0, except index 0, where AD_oe stays 1 with AD_out = 0xF0 (preloads write data).
- DATA, T_PH cycles:
  - Index 0: CS_n = 0, WR_n = 0, AD_oe = 1, AD_out = 0xF0.
  - Index 1..9: CS_n = 0, RD_n = 0, AD_oe = 0. AD_in is sampled into shadow[index] on the last DATA cycle only.
- GAP2, T_GAP cycles:
  - All strobes high, AD_oe = 0.
  - index = 9 -> COMMIT; else index++ and -> ADDR.
- COMMIT, 1 cycle:
  - All outputs load from shadow simultaneously; done = 1.
  - hora and hora_t = shadow & 0x1F if SF_24_12 = 1, else shadow & 0x3F.
  - AM_PM = shadow_hora[5] & SF_24_12.
  - -> IDLE, busy = 0 on the next cycle.

Bus rules:
- RD_n = 0 and AD_oe = 1 never occur in the same cycle.
- WR_n and RD_n are never both low.
- Every phase is separated by at least T_GAP idle cycles.

Latency:
- start to done = 10 × (2·T_PH + 2·T_GAP) + 2 cycles; 122 at defaults.

Boundary conditions:
- start asserted in the same cycle as COMMIT: ignored; a new start is accepted from IDLE only.
- Outputs hold previous values for the whole sequence; no torn reads.
- Reset mid-sequence: immediate return to reset values. Shadow values are discarded and outputs cleared; the next start begins again at index 0.
- SF_24_12 is sampled only at COMMIT.
- Phase counters are wide enough for T_PH, T_GAP ≤ 15.

Test Plan:
1. Reset low mid-DATA of index 4 -> strobes high and AD_oe = 0 in the same cycle, outputs 0, busy = 0. After release, start -> full sequence from index 0.
2. RTC model returns 0x45, 0x30, 0x13, 0x25, 0x12, 0x16, 0x10, 0x05, 0x01 (addresses 0x21..0x43), SF_24_12 = 0, start -> done at cycle 122. seg = 0x45, hora = 0x13, year = 0x16, hora_t = 0x01, AM_PM = 0.
3. Bus monitor across the full sequence -> exactly 1 WR data phase (0xF0 at address 0xF0) followed by 9 read phases. Address order matches the table. No RD_n/AD_oe overlap; every gap ≥ 2 cycles.
4. SF_24_12 = 1, hours raw 0x31 -> hora = 0x11, AM_PM = 1. Raw 0x11 -> AM_PM = 0.
5. Extra start pulses at cycles 5 and 60 of a sequence -> ignored, single done. Outputs unchanged until the COMMIT cycle, then all 9 change in the same edge.
6. T_PH = 2, T_GAP = 1 instance -> done latency 62 cycles; AD_in sampled on the 2nd DATA cycle, and a value change on the 1st cycle is not captured.
